// File: rtl/lsu_mem_stage.sv
//==============================================================================
// lsu_mem_stage : single-outstanding load/store stage on a req/ack data bus
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

module lsu_mem_stage #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   output logic            bus_req,
   output logic            bus_we,
   output logic [AW-1:0]   bus_addr,
   output logic [DW-1:0]   bus_wdata,
   output logic [DW/8-1:0] bus_be,
   input  logic            bus_ack,
   input  logic [DW-1:0]   bus_rdata,
   output logic            rsp_valid,
   output logic [DW-1:0]   rsp_rdata,
   output logic            rsp_misalign,
   output logic            stall
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]      r_state;
   logic            r_bus_req;
   logic            r_bus_we;
   logic [AW-1:0]   r_bus_addr;
   logic [DW-1:0]   r_bus_wdata;
   logic [DW/8-1:0] r_bus_be;
   logic            r_rsp_valid;
   logic [DW-1:0]   r_rsp_rdata;
   logic            r_rsp_misalign;
   logic [1:0]      r_size;
   logic            r_unsigned;
   logic [1:0]      r_alo;

   logic            w_accept;
   logic            w_fault;
   logic [DW/8-1:0] w_be;
   logic [DW-1:0]   w_wdata;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [DW-1:0]   w_ld;

   assign req_ready = (r_state == S_IDLE);
   assign w_accept  = req_valid & req_ready;
   assign stall     = (req_valid & ~req_ready) | (r_state == S_BUSY);

   always_comb begin
      w_fault = 1'b0;
      case (req_size)
         2'b00:   w_fault = 1'b0;
         2'b01:   w_fault = req_addr[0];
         2'b10:   w_fault = |req_addr[1:0];
         default: w_fault = 1'b1;
      endcase
   end

   // Store data is replicated across all lanes; the enables pick the live ones.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = req_wdata;
      case (req_size)
         2'b00: begin
            w_be    = 4'b0001 << req_addr[1:0];
            w_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{req_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = req_wdata;
         end
      endcase
      if (!req_we) begin
         w_be = 4'b1111;
      end
   end

   always_comb begin
      w_byte = bus_rdata[7:0];
      case (r_alo)
         2'd0:    w_byte = bus_rdata[7:0];
         2'd1:    w_byte = bus_rdata[15:8];
         2'd2:    w_byte = bus_rdata[23:16];
         default: w_byte = bus_rdata[31:24];
      endcase
      w_half = r_alo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (r_size)
         2'b00:   w_ld = {{24{~r_unsigned & w_byte[7]}}, w_byte};
         2'b01:   w_ld = {{16{~r_unsigned & w_half[15]}}, w_half};
         default: w_ld = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_bus_req      <= 1'b0;
         r_bus_we       <= 1'b0;
         r_bus_addr     <= '0;
         r_bus_wdata    <= '0;
         r_bus_be       <= '0;
         r_rsp_valid    <= 1'b0;
         r_rsp_rdata    <= '0;
         r_rsp_misalign <= 1'b0;
         r_size         <= 2'b00;
         r_unsigned     <= 1'b0;
         r_alo          <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_fault) begin
                  r_state        <= S_RESP;
                  r_rsp_valid    <= 1'b1;
                  r_rsp_misalign <= 1'b1;
                  r_rsp_rdata    <= '0;
               end else if (w_accept) begin
                  r_state     <= S_BUSY;
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= req_we;
                  r_bus_addr  <= {req_addr[AW-1:2], 2'b00};
                  r_bus_wdata <= w_wdata;
                  r_bus_be    <= w_be;
                  r_size      <= req_size;
                  r_unsigned  <= req_unsigned;
                  r_alo       <= req_addr[1:0];
               end
            end
            S_BUSY: begin
               if (bus_ack) begin
                  r_state        <= S_RESP;
                  r_bus_req      <= 1'b0;
                  r_rsp_valid    <= 1'b1;
                  r_rsp_misalign <= 1'b0;
                  r_rsp_rdata    <= r_bus_we ? '0 : w_ld;
               end
            end
            S_RESP: begin
               r_state        <= S_IDLE;
               r_rsp_valid    <= 1'b0;
               r_rsp_misalign <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus_req      = r_bus_req;
   assign bus_we       = r_bus_we;
   assign bus_addr     = r_bus_addr;
   assign bus_wdata    = r_bus_wdata;
   assign bus_be       = r_bus_be;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_rdata    = r_rsp_rdata;
   assign rsp_misalign = r_rsp_misalign;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
//==============================================================================
// tb_lsu_mem_stage : directed stimulus with queue-based response/bus scoreboard
//==============================================================================
`default_nettype none

module tb_lsu_mem_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_misalign;
   logic        stall;

   lsu_mem_stage #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
      .bus_rdata(bus_rdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_misalign(rsp_misalign), .stall(stall)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rdata;
      logic        mis;
   } rsp_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        chk_wd;
   } bus_t;

   rsp_t rsp_q[$];
   bus_t bus_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Response monitor
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (!rst && rsp_valid) begin
            if (rsp_q.size() == 0) begin
               check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               e = rsp_q.pop_front();
               check("rsp_rdata", rsp_rdata, e.rdata);
               check("rsp_misalign", {31'd0, rsp_misalign}, {31'd0, e.mis});
            end
         end
      end
   end

   // Bus monitor: first cycle of bus_req checked against queue, later cycles for stability
   initial begin
      bus_t e;
      logic prev_req;
      logic [68:0] snap;
      prev_req = 1'b0;
      snap = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_req = 1'b0;
         end else begin
            if (bus_req && !prev_req) begin
               if (bus_q.size() == 0) begin
                  check("bus_unexpected", 32'd1, 32'd0);
               end else begin
                  e = bus_q.pop_front();
                  check("bus_we", {31'd0, bus_we}, {31'd0, e.we});
                  check("bus_addr", bus_addr, e.addr);
                  check("bus_be", {28'd0, bus_be}, {28'd0, e.be});
                  if (e.chk_wd) check("bus_wdata", bus_wdata, e.wdata);
               end
               snap = {bus_we, bus_addr, bus_wdata, bus_be};
            end else if (bus_req) begin
               check("bus_stable", {31'd0, ({bus_we, bus_addr, bus_wdata, bus_be} == snap)}, 32'd1);
            end
            prev_req = bus_req;
         end
      end
   end

   task automatic issue(input logic we, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd, input int dly,
                        input logic [31:0] rd, input logic [31:0] exp_rd, input logic flt,
                        input logic [3:0] be, input logic [31:0] bwd);
      rsp_t r;
      bus_t b;
      r.rdata = exp_rd;
      r.mis   = flt;
      rsp_q.push_back(r);
      if (!flt) begin
         b.we = we; b.addr = {a[31:2], 2'b00}; b.wdata = bwd; b.be = be; b.chk_wd = we;
         bus_q.push_back(b);
      end
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = un;
      req_addr = a; req_wdata = wd;
      check("ready_idle", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (flt) begin
         check("fault_rsp_lat", {31'd0, rsp_valid}, 32'd1);
         check("fault_no_bus", {31'd0, bus_req}, 32'd0);
      end else begin
         check("bus_req_start", {31'd0, bus_req}, 32'd1);
         for (int i = 0; i < dly; i++) begin
            check("stall_busy", {31'd0, stall}, 32'd1);
            check("ready_busy", {31'd0, req_ready}, 32'd0);
            check("rsp_early", {31'd0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
         end
         bus_ack = 1'b1; bus_rdata = rd;
         @(posedge clk); #1;
         bus_ack = 1'b0; bus_rdata = $urandom;
         check("rsp_lat", {31'd0, rsp_valid}, 32'd1);
         check("bus_req_drop", {31'd0, bus_req}, 32'd0);
      end
      @(posedge clk); #1;
      check("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
      check("ready_after", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      check("rst_bus_req", {31'd0, bus_req}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_bus_be", {28'd0, bus_be}, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_stall", {31'd0, stall}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      //     we sz    un  addr          wdata         dly rdata         exp           flt be       bus_wdata
      issue(0, 2'b10, 0, 32'h0000_0100, 32'h0,         0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0);
      issue(0, 2'b00, 0, 32'h0000_0103, 32'h0,         1, 32'h8000_0000, 32'hFFFF_FF80, 0, 4'b1111, 32'h0);
      issue(0, 2'b00, 1, 32'h0000_0103, 32'h0,         0, 32'h8000_0000, 32'h0000_0080, 0, 4'b1111, 32'h0);
      issue(0, 2'b00, 0, 32'h0000_0101, 32'h0,         2, 32'h0000_7F00, 32'h0000_007F, 0, 4'b1111, 32'h0);
      issue(0, 2'b01, 0, 32'h0000_0102, 32'h0,         0, 32'h8001_7FFF, 32'hFFFF_8001, 0, 4'b1111, 32'h0);
      issue(0, 2'b01, 1, 32'h0000_0102, 32'h0,         0, 32'h8001_7FFF, 32'h0000_8001, 0, 4'b1111, 32'h0);
      issue(0, 2'b01, 0, 32'h0000_0100, 32'h0,         1, 32'h1234_8765, 32'hFFFF_8765, 0, 4'b1111, 32'h0);
      issue(1, 2'b01, 0, 32'h0000_0202, 32'h1234_ABCD, 0, 32'h5555_5555, 32'h0,         0, 4'b1100, 32'hABCD_ABCD);
      issue(1, 2'b01, 0, 32'h0000_0200, 32'h1234_ABCD, 0, 32'h0,         32'h0,         0, 4'b0011, 32'hABCD_ABCD);
      issue(1, 2'b00, 0, 32'h0000_0105, 32'h0000_00A5, 5, 32'h0,         32'h0,         0, 4'b0010, 32'hA5A5_A5A5);
      issue(1, 2'b10, 0, 32'h0000_0300, 32'hCAFE_F00D, 0, 32'h0,         32'h0,         0, 4'b1111, 32'hCAFE_F00D);
      issue(0, 2'b10, 0, 32'h0000_0101, 32'h0,         0, 32'h0,         32'h0,         1, 4'b0000, 32'h0);
      issue(0, 2'b01, 0, 32'h0000_0103, 32'h0,         0, 32'h0,         32'h0,         1, 4'b0000, 32'h0);
      issue(1, 2'b11, 0, 32'h0000_0100, 32'h0,         0, 32'h0,         32'h0,         1, 4'b0000, 32'h0);

      // Stray ack while idle must be ignored (monitor flags any response)
      bus_ack = 1'b1;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      check("idle_ack_ignored", {31'd0, rsp_valid}, 32'd0);

      // Reset while busy: bus_req drops immediately, op discarded
      begin
         bus_t b;
         b.we = 1'b0; b.addr = 32'h0000_0400; b.wdata = 32'h0; b.be = 4'b1111; b.chk_wd = 1'b0;
         bus_q.push_back(b);
      end
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0400;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("busy_before_rst", {31'd0, bus_req}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_req", {31'd0, bus_req}, 32'd0);
      check("rst_async_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      bus_ack = 1'b1;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      check("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check("rst_ready_after", {31'd0, req_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("rsp_q_drained", rsp_q.size(), 32'd0);
      check("bus_q_drained", bus_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
